uart_fifo_ctrl: RTL

UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_fifo_ptr.sv | 37 +++
 rtl/uart_fifo_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and status payload for the UART FIFO controller.
package uart_pkg;

  localparam int unsigned UART_FIFO_DEPTH_DEFAULT = 16;
  localparam int unsigned UART_FIFO_CNT_W         = 16;

  typedef struct packed {
    logic [UART_FIFO_CNT_W-1:0] count;
    logic                       full;
    logic                       empty;
    logic                       thresh_hit;
    logic                       overflow;
    logic                       underflow;
  } uart_fifo_status_t;

  localparam uart_fifo_status_t UART_FIFO_STATUS_RST = '{
    count:      '0,
    full:       1'b0,
    empty:      1'b1,
    thresh_hit: 1'b0,
    overflow:   1'b0,
    underflow:  1'b0
  };

endpackage

// File: rtl/uart_fifo_ptr.sv
// Wrap-bit pointer counter: AW address bits plus one wrap bit, with
// synchronous clear taking priority over increment.
module uart_fifo_ptr #(
  parameter int unsigned AW = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [AW-1:0] addr_o,
  output logic [AW:0]   ptr_nxt_c
);

  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] ptr_q;

  always_comb begin
    ptr_nxt_c = ptr_q;
    if (clr_i) begin
      ptr_nxt_c = '0;
    end else if (inc_i) begin
      ptr_nxt_c = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_nxt_c;
    end
  end

  assign addr_o = ptr_q[AW-1:0];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// FIFO pointer/flag controller for the UART data path; the storage RAM is
// external and driven through the ram_* strobes and addresses.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          wr_req_i,
  input  logic          rd_req_i,
  input  logic          flush_i,
  input  logic          err_clr_i,
  input  logic [AW:0]   thresh_i,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_waddr_o,
  output logic          ram_re_o,
  output logic [AW-1:0] ram_raddr_o,
  output logic          rd_valid_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          thresh_hit_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  logic              wr_acc_c;
  logic              rd_acc_c;
  logic              ovf_set_c;
  logic              unf_set_c;
  logic [AW:0]       wptr_nxt_c;
  logic [AW:0]       rptr_nxt_c;
  uart_fifo_status_t st_q;
  uart_fifo_status_t st_d;
  logic              rd_valid_q;

  // A read frees a slot in the same cycle, so a write at full is still taken.
  assign rd_acc_c  = rd_req_i & ~st_q.empty & ~flush_i;
  assign wr_acc_c  = wr_req_i & (~st_q.full | rd_acc_c) & ~flush_i;
  assign ovf_set_c = wr_req_i & st_q.full & ~rd_acc_c & ~flush_i;
  assign unf_set_c = rd_req_i & st_q.empty & ~flush_i;

  uart_fifo_ptr #(.AW(AW)) u_wptr (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .inc_i     (wr_acc_c),
    .clr_i     (flush_i),
    .addr_o    (ram_waddr_o),
    .ptr_nxt_c (wptr_nxt_c)
  );

  uart_fifo_ptr #(.AW(AW)) u_rptr (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .inc_i     (rd_acc_c),
    .clr_i     (flush_i),
    .addr_o    (ram_raddr_o),
    .ptr_nxt_c (rptr_nxt_c)
  );

  // Flags are computed from next-state values so they land with the access.
  always_comb begin
    st_d = st_q;
    if (flush_i) begin
      st_d.count = '0;
    end else if (wr_acc_c && !rd_acc_c) begin
      st_d.count = st_q.count + UART_FIFO_CNT_W'(1);
    end else if (!wr_acc_c && rd_acc_c) begin
      st_d.count = st_q.count - UART_FIFO_CNT_W'(1);
    end
    st_d.empty      = (wptr_nxt_c == rptr_nxt_c);
    st_d.full       = (wptr_nxt_c[AW-1:0] == rptr_nxt_c[AW-1:0]) &&
                      (wptr_nxt_c[AW] != rptr_nxt_c[AW]);
    st_d.thresh_hit = (thresh_i != '0) &&
                      (st_d.count >= UART_FIFO_CNT_W'(thresh_i));
    st_d.overflow   = ovf_set_c | (st_q.overflow & ~err_clr_i);
    st_d.underflow  = unf_set_c | (st_q.underflow & ~err_clr_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st_q       <= UART_FIFO_STATUS_RST;
      rd_valid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      rd_valid_q <= rd_acc_c;
    end
  end

  assign ram_we_o     = wr_acc_c;
  assign ram_re_o     = rd_acc_c;
  assign rd_valid_o   = rd_valid_q;
  assign count_o      = st_q.count[AW:0];
  assign full_o       = st_q.full;
  assign empty_o      = st_q.empty;
  assign thresh_hit_o = st_q.thresh_hit;
  assign overflow_o   = st_q.overflow;
  assign underflow_o  = st_q.underflow;

endmodule
